// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// Optional feature macro: DEBOUNCE_RELEASE_PULSE_EN.
package debounce_pkg;

  typedef enum logic [1:0] {
    DB_IDLE       = 2'd0,
    DB_PRESS_WAIT = 2'd1,
    DB_HELD       = 2'd2,
    DB_REL_WAIT   = 2'd3
  } db_state_t;

  localparam int DB_SYNC_STAGES = 2;
  localparam int DB_MIN_STABLE  = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
// Synchronous active-high reset clears both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  // Two-stage metastability filter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule

// File: rtl/debounce_pulse.sv
// Button debouncer: 2FF sync, stable-count filter, press/release pulses.
// Macro DEBOUNCE_RELEASE_PULSE_EN builds the release-pulse flop.
module debounce_pulse #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press_pulse,
  output logic rel_pulse
);

  import debounce_pkg::*;

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  generate
    if (STABLE_CYCLES < DB_MIN_STABLE) begin : g_bad_param
      $error("debounce_pulse: STABLE_CYCLES must be >= 2");
    end
  endgenerate

  logic          w_sync;
  db_state_t     r_state;
  db_state_t     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_level;
  logic          w_level_nxt;
  logic          r_press;
  logic          w_press_nxt;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic          r_rel;
  logic          w_rel_nxt;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (w_sync)
  );

  // Next state, counter and output decisions
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_press_nxt = 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    w_rel_nxt   = 1'b0;
`endif
    unique case (r_state)
      DB_IDLE: begin
        w_cnt_nxt = '0;
        if (w_sync) begin
          w_state_nxt = DB_PRESS_WAIT;
          w_cnt_nxt   = ONE;
        end
      end
      DB_PRESS_WAIT: begin
        if (!w_sync) begin
          w_state_nxt = DB_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST) begin
          w_state_nxt = DB_HELD;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end
      DB_HELD: begin
        w_cnt_nxt = '0;
        if (!w_sync) begin
          w_state_nxt = DB_REL_WAIT;
          w_cnt_nxt   = ONE;
        end
      end
      DB_REL_WAIT: begin
        if (w_sync) begin
          w_state_nxt = DB_HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST) begin
          w_state_nxt = DB_IDLE;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
          w_rel_nxt   = 1'b1;
`endif
        end else begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end
      default: begin
        w_state_nxt = DB_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= DB_IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_press <= w_press_nxt;
    end
  end

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  // Release pulse flop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rel <= 1'b0;
    end else begin
      r_rel <= w_rel_nxt;
    end
  end

  assign rel_pulse = r_rel;
`else
  assign rel_pulse = 1'b0;
`endif

  assign level       = r_level;
  assign press_pulse = r_press;

endmodule

// File: tb/tb_debounce_pulse.sv
// Self-checking bench for debounce_pulse (STABLE_CYCLES=4).
// Works with or without DEBOUNCE_RELEASE_PULSE_EN defined.
module tb_debounce_pulse;

  localparam int SC = 4;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  localparam int REL_EXP = 1;
`else
  localparam int REL_EXP = 0;
`endif

  logic clk;
  logic reset;
  logic btn_in;
  logic level;
  logic press_pulse;
  logic rel_pulse;

  debounce_pulse #(.STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .level       (level),
    .press_pulse (press_pulse),
    .rel_pulse   (rel_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream toggle register fed by press_pulse
  logic tog;
  always @(posedge clk) begin
    if (reset) tog <= 1'b0;
    else if (press_pulse) tog <= ~tog;
  end

  int   vecs = 0;
  int   errs = 0;
  logic hist[$];
  int   rst_at = -1;
  logic m_level = 1'b0;
  logic m_press = 1'b0;
  logic m_rel   = 1'b0;
  int   press_seen = 0;
  int   rel_seen   = 0;
  int   last_press = -1;
  int   last_fall  = -1;
  logic prev_level = 1'b0;

  task automatic chk(input string tag,
                     input logic obs,
                     input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0b expected=%0b",
             tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag,
                         input int obs,
                         input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // Value the filter sees at edge i: the raw sample two edges
  // earlier, or 0 while the synchronizer is still flushed by reset.
  function automatic logic sync_at(input int i);
    if (i - 2 > rst_at) return hist[i-2];
    return 1'b0;
  endfunction

  // One clock edge: drive, clock, update model, compare.
  task automatic step(input logic b, input logic r);
    int  k;
    logic flip;
    btn_in = b;
    reset  = r;
    @(posedge clk);
    #1;
    k = hist.size();
    hist.push_back(b);
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (r) begin
      rst_at  = k;
      m_level = 1'b0;
    end else if (k - SC + 1 > rst_at) begin
      flip = 1'b1;
      for (int i = k - SC + 1; i <= k; i++)
        if (sync_at(i) == m_level) flip = 1'b0;
      if (flip) begin
        m_level = ~m_level;
        if (m_level) m_press = 1'b1;
        else m_rel = (REL_EXP == 1);
      end
    end
    chk("level", level, m_level);
    chk("press_pulse", press_pulse, m_press);
    chk("rel_pulse", rel_pulse, m_rel);
    if (press_pulse === 1'b1) begin
      press_seen++;
      last_press = k;
    end
    if (rel_pulse === 1'b1) rel_seen++;
    if (prev_level === 1'b1 && level === 1'b0)
      last_fall = k;
    prev_level = level;
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  initial begin
    int   e0;
    logic t0;
    logic v;
    int   len;

    btn_in = 1'b0;
    reset  = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    run(1'b0, 3);

    // Clean press
    e0 = hist.size();
    press_seen = 0;
    t0 = tog;
    run(1'b1, 10);
    chk_int("clean_press_cnt", press_seen, 1);
    chk_int("clean_press_edge", last_press, e0 + SC + 1);
    chk("toggle_once", tog, ~t0);

    // Release
    e0 = hist.size();
    rel_seen = 0;
    run(1'b0, 10);
    chk_int("release_fall_edge", last_fall, e0 + SC + 1);
    chk_int("release_rel_cnt", rel_seen, REL_EXP);

    // Glitch: three high samples only
    press_seen = 0;
    run(1'b1, 3);
    run(1'b0, 10);
    chk_int("glitch_press_cnt", press_seen, 0);

    // Bounce then hold: 1,0,1,1,0,1...
    press_seen = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    e0 = hist.size();
    run(1'b1, 12);
    chk_int("bounce_press_cnt", press_seen, 1);
    chk_int("bounce_press_edge", last_press, e0 + SC + 1);
    run(1'b0, 10);

    // Long hold and release
    press_seen = 0;
    rel_seen   = 0;
    run(1'b1, 100);
    chk_int("long_press_cnt", press_seen, 1);
    e0 = hist.size();
    run(1'b0, 10);
    chk_int("long_fall_edge", last_fall, e0 + SC + 1);
    chk_int("long_rel_cnt", rel_seen, REL_EXP);

    // Reset while in PRESS_WAIT with cnt=2
    press_seen = 0;
    run(1'b1, 4);
    step(1'b1, 1'b1);
    chk("rst_level", level, 1'b0);
    chk("rst_press", press_pulse, 1'b0);
    chk("rst_rel", rel_pulse, 1'b0);
    e0 = hist.size();
    run(1'b1, 10);
    chk_int("requal_press_cnt", press_seen, 1);
    chk_int("requal_press_edge", last_press, e0 + SC + 1);
    run(1'b0, 10);

    // Random bursts with occasional reset
    for (int n = 0; n < 120; n++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      if ($urandom_range(0, 24) == 0) step(v, 1'b1);
      run(v, len);
    end
    run(1'b0, 10);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
